vis_bytepacker: RTL and testbench



---
 rtl/vis_pkg.sv | 22 ++
 rtl/crc8_byte.sv | 28 ++
 rtl/vis_bytepacker.sv | 213 +++++++++++++++++++++
 tb/tb_vis_bytepacker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vis_pkg.sv
// ----------------------------------------------------------------------------
// vis_pkg
//   Shared definitions for the visibility byte packer.
//   - state_t      : packer FSM states
//   - SYNC_DEFAULT : default frame sync byte
//   - CRC8_POLY    : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
// ----------------------------------------------------------------------------
package vis_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_SEQ  = 3'd2,
        S_DATA = 3'd3,
        S_WAIT = 3'd4,
        S_CRC  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

endpackage

// File: rtl/crc8_byte.sv
// ----------------------------------------------------------------------------
// crc8_byte
//   Combinational one-byte CRC-8 update: MSB-first, no reflection, no final
//   XOR, polynomial CRC8_POLY.
//   Ports:
//     i_crc  in  8  current CRC value
//     i_byte in  8  byte being folded in
//     o_crc  out 8  CRC after i_byte
// ----------------------------------------------------------------------------
module crc8_byte
    import vis_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] w_c;

    always_comb begin
        w_c = i_crc ^ i_byte;
        for (int b = 0; b < 8; b++) begin
            w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/vis_bytepacker.sv
// ----------------------------------------------------------------------------
// vis_bytepacker
//   Serialises the 2*ACCUM-bit {revis, imvis} visibility stream into bytes.
//   Each frame is prefixed with a sync byte and an 8-bit sequence number;
//   data bytes go revis first then imvis, each least-significant byte first.
//
//   Optional feature (macro VIS_BYTEPACKER_CRC_EN): a CRC-8 over the SEQ and
//   data bytes is appended as an extra byte carrying m_tlast_o.
//
//   Ports:
//     clock       in   1         bus clock
//     reset       in   1         synchronous, active-high reset
//     s_tvalid_i  in   1         input beat valid
//     s_tready_o  out  1         input beat accepted (combinational)
//     s_tlast_i   in   1         last beat of visibility frame
//     s_tdata_i   in   2*ACCUM   {revis, imvis}
//     m_tvalid_o  out  1         output byte valid (registered)
//     m_tready_i  in   1         downstream ready
//     m_tlast_o   out  1         last byte of frame
//     m_tdata_o   out  8         output byte
//     busy_o      out  1         FSM not idle
// ----------------------------------------------------------------------------
module vis_bytepacker
    import vis_pkg::*;
#(
    parameter int         ACCUM = 32,
    parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               s_tvalid_i,
    output logic               s_tready_o,
    input  logic               s_tlast_i,
    input  logic [2*ACCUM-1:0] s_tdata_i,
    output logic               m_tvalid_o,
    input  logic               m_tready_i,
    output logic               m_tlast_o,
    output logic [7:0]         m_tdata_o,
    output logic               busy_o
);

    localparam int NBYTES = 2 * ACCUM / 8;
    localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef logic [BIW-1:0] bi_t;
    localparam bi_t BI_LAST = bi_t'(NBYTES - 1);

    state_t             r_state, w_state_d;
    logic [2*ACCUM-1:0] r_hold,  w_hold_d;
    logic               r_last,  w_last_d;
    bi_t                r_bi,    w_bi_d;
    logic [7:0]         r_seq,   w_seq_d;
    logic               r_mvalid, w_mvalid_d;
    logic               r_mlast,  w_mlast_d;
    logic [7:0]         r_mdata,  w_mdata_d;
    logic               w_xfer, w_accept, w_bi_end, w_load;

    assign w_xfer   = r_mvalid & m_tready_i;
    assign w_bi_end = (r_bi == BI_LAST);

    // Ready in DATA only on the final byte of a non-last beat, so the next
    // beat is loaded in the same cycle that byte leaves (no bubble).
    always_comb begin
        s_tready_o = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: s_tready_o = 1'b1;
            S_DATA:         s_tready_o = w_bi_end & ~r_last & m_tready_i;
            default:        s_tready_o = 1'b0;
        endcase
    end

    assign w_accept = s_tvalid_i & s_tready_o;

`ifdef VIS_BYTEPACKER_CRC_EN
    logic [7:0] r_crc, w_crc_d, w_crc_step;

    crc8_byte u_crc (
        .i_crc  (r_crc),
        .i_byte (r_mdata),
        .o_crc  (w_crc_step)
    );

    // Cleared while the sync byte is on the bus; folds in every SEQ/DATA
    // byte as it is transferred.
    always_comb begin
        w_crc_d = r_crc;
        if (r_state == S_SYNC)
            w_crc_d = 8'h00;
        else if (w_xfer && (r_state == S_SEQ || r_state == S_DATA))
            w_crc_d = w_crc_step;
    end

    always_ff @(posedge clock) begin
        if (reset) r_crc <= 8'h00;
        else       r_crc <= w_crc_d;
    end
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_last   <= 1'b0;
            r_bi     <= '0;
            r_seq    <= 8'h00;
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            r_mdata  <= 8'h00;
        end else begin
            r_state  <= w_state_d;
            r_hold   <= w_hold_d;
            r_last   <= w_last_d;
            r_bi     <= w_bi_d;
            r_seq    <= w_seq_d;
            r_mvalid <= w_mvalid_d;
            r_mlast  <= w_mlast_d;
            r_mdata  <= w_mdata_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_d = r_state;
        w_last_d  = r_last;
        w_bi_d    = r_bi;
        w_seq_d   = r_seq;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_d = S_SYNC;
                w_load    = 1'b1;
            end
            S_SYNC: if (w_xfer) w_state_d = S_SEQ;
            S_SEQ: if (w_xfer) begin
                w_state_d = S_DATA;
                w_bi_d    = '0;
            end
            S_DATA: if (w_xfer) begin
                if (!w_bi_end) begin
                    w_bi_d = r_bi + bi_t'(1);
                end else if (!r_last) begin
                    w_bi_d = '0;
                    if (w_accept) w_load    = 1'b1;
                    else          w_state_d = S_WAIT;
                end else begin
                    w_seq_d = r_seq + 8'd1;
`ifdef VIS_BYTEPACKER_CRC_EN
                    w_state_d = S_CRC;
`else
                    w_state_d = S_IDLE;
`endif
                end
            end
            S_WAIT: if (w_accept) begin
                w_state_d = S_DATA;
                w_bi_d    = '0;
                w_load    = 1'b1;
            end
            S_CRC: if (w_xfer) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
        // Hold register is stored as {imvis, revis} so byte k is simply
        // bits [8k +: 8] in output order.
        w_hold_d = r_hold;
        if (w_load) begin
            w_hold_d = {s_tdata_i[ACCUM-1:0], s_tdata_i[2*ACCUM-1:ACCUM]};
            w_last_d = s_tlast_i;
        end
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the next state and registered, so they stay
    // frozen whenever the FSM does not advance (backpressure).
    always_comb begin
        w_mvalid_d = 1'b0;
        w_mlast_d  = 1'b0;
        w_mdata_d  = 8'h00;
        case (w_state_d)
            S_SYNC: begin
                w_mvalid_d = 1'b1;
                w_mdata_d  = SYNC;
            end
            S_SEQ: begin
                w_mvalid_d = 1'b1;
                w_mdata_d  = w_seq_d;
            end
            S_DATA: begin
                w_mvalid_d = 1'b1;
                w_mdata_d  = w_hold_d[8*int'(w_bi_d) +: 8];
`ifndef VIS_BYTEPACKER_CRC_EN
                w_mlast_d  = w_last_d & (w_bi_d == BI_LAST);
`endif
            end
`ifdef VIS_BYTEPACKER_CRC_EN
            S_CRC: begin
                w_mvalid_d = 1'b1;
                w_mdata_d  = w_crc_d;
                w_mlast_d  = 1'b1;
            end
`endif
            default: begin
                w_mvalid_d = 1'b0;
            end
        endcase
    end

    assign m_tvalid_o = r_mvalid;
    assign m_tlast_o  = r_mlast;
    assign m_tdata_o  = r_mdata;
    assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_vis_bytepacker.sv
module tb_vis_bytepacker;

    localparam int ACCUM = 32;
    localparam int NB    = 2 * ACCUM / 8;
`ifdef VIS_BYTEPACKER_CRC_EN
    localparam int NCRC = 1;
`else
    localparam int NCRC = 0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               s_tvalid_i, s_tready_o, s_tlast_i;
    logic [2*ACCUM-1:0] s_tdata_i;
    logic               m_tvalid_o, m_tready_i, m_tlast_o;
    logic [7:0]         m_tdata_o;
    logic               busy_o;

    always #5 clock = ~clock;

    vis_bytepacker #(.ACCUM(ACCUM), .SYNC(8'hA5)) dut (
        .clock      (clock),
        .reset      (reset),
        .s_tvalid_i (s_tvalid_i),
        .s_tready_o (s_tready_o),
        .s_tlast_i  (s_tlast_i),
        .s_tdata_i  (s_tdata_i),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tlast_o  (m_tlast_o),
        .m_tdata_o  (m_tdata_o),
        .busy_o     (busy_o)
    );

    typedef struct packed {
        logic [2*ACCUM-1:0] d;
        logic               l;
    } beat_t;

    beat_t      src_q[$];
    logic [8:0] exp_q[$];   // {last, byte}
    logic [7:0] mseq = 8'h00;

    int checks = 0, errors = 0;
    int rdy_mode = 0, gap_pct = 0, pat_i = 0;
    int xfer_cnt = 0, vld_cnt = 0, trdy_busy_cnt = 0;
    logic       prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial polynomial division of the message, MSB-first.
    function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r = c;
        for (int i = 7; i >= 0; i--) begin
            logic fb = r[7] ^ b[i];
            r = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    // Reference model: enqueue beats to send and the exact byte stream
    // the frame must produce.
    task automatic add_frame(input int nb, input logic use_fix, input logic [2*ACCUM-1:0] fix);
        logic [7:0] crc;
        logic [7:0] b;
        logic [2*ACCUM-1:0] d;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, mseq});
        crc = crc_bits(8'h00, mseq);
        for (int i = 0; i < nb; i++) begin
            d = use_fix ? fix : {$urandom, $urandom};
            src_q.push_back('{d: d, l: (i == nb - 1)});
            for (int k = 0; k < NB; k++) begin
                if (k < NB / 2) b = d[ACCUM + 8*k +: 8];
                else            b = d[8*(k - NB/2) +: 8];
                crc = crc_bits(crc, b);
                exp_q.push_back({(i == nb - 1) && (k == NB - 1) && (NCRC == 0), b});
            end
        end
        if (NCRC != 0) exp_q.push_back({1'b1, crc});
        mseq = mseq + 8'd1;
    endtask

    task automatic tick();
        logic acc;
        logic [8:0] e;
        @(negedge clock);
        if (prev_stall) begin
            chk("hold_valid", 32'(m_tvalid_o), 32'd1);
            chk("hold_data", 32'(m_tdata_o), 32'(prev_data));
            chk("hold_last", 32'(m_tlast_o), 32'(prev_last));
        end
        if (!reset && m_tvalid_o) vld_cnt++;
        if (!reset && m_tvalid_o && m_tready_i) begin
            xfer_cnt++;
            if (exp_q.size() == 0) chk("extra_byte", 32'(m_tdata_o), 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("byte", 32'(m_tdata_o), 32'(e[7:0]));
                chk("last", 32'(m_tlast_o), 32'(e[8]));
            end
        end
        if (!reset && busy_o && s_tready_o) trdy_busy_cnt++;
        acc        = s_tvalid_i && s_tready_o && !reset;
        prev_stall = m_tvalid_o && !m_tready_i && !reset;
        prev_data  = m_tdata_o;
        prev_last  = m_tlast_o;
        @(posedge clock);
        #1;
        if (acc) void'(src_q.pop_front());
        if (!(s_tvalid_i && !acc)) begin
            if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                s_tvalid_i = 1'b1;
                s_tdata_i  = src_q[0].d;
                s_tlast_i  = src_q[0].l;
            end else begin
                s_tvalid_i = 1'b0;
                s_tdata_i  = {$urandom, $urandom};
                s_tlast_i  = 1'($urandom_range(1));
            end
        end
        case (rdy_mode)
            1:       m_tready_i = 1'($urandom_range(1));
            2: begin
                m_tready_i = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                pat_i++;
            end
            default: m_tready_i = 1'b1;
        endcase
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || busy_o) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = '0;
        m_tready_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mvalid", 32'(m_tvalid_o), 32'd0);
        chk("rst_mlast", 32'(m_tlast_o), 32'd0);
        chk("rst_mdata", 32'(m_tdata_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_sready", 32'(s_tready_o), 32'd1);
        reset = 1'b0;

        // single-beat directed frame
        add_frame(1, 1'b1, 64'h11223344_AABBCCDD);
        drain(200);

        // two-beat frame, continuous valid, full-rate downstream
        xfer_cnt = 0; vld_cnt = 0; trdy_busy_cnt = 0;
        add_frame(2, 1'b0, '0);
        drain(200);
        chk("two_beat_xfers", 32'(xfer_cnt), 32'(2 + 2*NB + NCRC));
        chk("two_beat_vld_cycles", 32'(vld_cnt), 32'(2 + 2*NB + NCRC));
        chk("two_beat_sready_pulses", 32'(trdy_busy_cnt), 32'd1);

        // backpressure 1-0-0-1 with input gaps
        rdy_mode = 2; gap_pct = 30;
        for (int f = 0; f < 12; f++) add_frame(int'($urandom_range(1, 4)), 1'b0, '0);
        drain(3000);

        // random backpressure
        rdy_mode = 1; gap_pct = 20;
        for (int f = 0; f < 12; f++) add_frame(int'($urandom_range(1, 3)), 1'b0, '0);
        drain(3000);

        // reset after 4th data byte of a beat
        rdy_mode = 0; gap_pct = 0;
        xfer_cnt = 0;
        add_frame(1, 1'b0, '0);
        for (int n = 0; n < 100 && xfer_cnt < 6; n++) tick();
        chk("pre_reset_xfers", 32'(xfer_cnt), 32'd6);
        reset = 1'b1; m_tready_i = 1'b0;
        tick();
        chk("midrst_mvalid", 32'(m_tvalid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        exp_q.delete(); src_q.delete(); mseq = 8'h00;
        add_frame(1, 1'b0, '0);
        drain(200);

`ifdef VIS_BYTEPACKER_CRC_EN
        add_frame(1, 1'b1, 64'h0);
        add_frame(1, 1'b1, 64'h1);
        drain(200);
`endif

        // sequence wrap from a clean start
        reset = 1'b1; tick(); reset = 1'b0;
        exp_q.delete(); src_q.delete(); mseq = 8'h00;
        for (int f = 0; f < 257; f++) add_frame(1, 1'b0, '0);
        drain(6000);
        chk("seq_model_wrapped", 32'(mseq), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
